// File: rtl/bp_commit_trace_aligner.sv
// Aligns retired commits with their register writebacks into one trace record
// per instruction. Traps are carried through the commit queue with their cause.
// A sticky error state freezes the block until reset.
module bp_commit_trace_aligner #(
  parameter int unsigned vaddr_width_p    = 39,
  parameter int unsigned instr_width_p    = 32,
  parameter int unsigned dword_width_p    = 64,
  parameter int unsigned reg_addr_width_p = 5,
  parameter int unsigned els_p            = 8,
  parameter int unsigned timeout_p        = 1024
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,

  input  logic                        commit_v_i,
  input  logic [vaddr_width_p-1:0]    commit_pc_i,
  input  logic [instr_width_p-1:0]    commit_instr_i,
  input  logic                        commit_rd_w_v_i,
  input  logic [reg_addr_width_p-1:0] commit_rd_addr_i,
  input  logic                        interrupt_v_i,
  input  logic [dword_width_p-1:0]    cause_i,

  input  logic                        wb_v_i,
  input  logic [reg_addr_width_p-1:0] wb_addr_i,
  input  logic [dword_width_p-1:0]    wb_data_i,

  output logic                        trace_v_o,
  input  logic                        trace_ready_i,
  output logic [vaddr_width_p-1:0]    trace_pc_o,
  output logic [instr_width_p-1:0]    trace_instr_o,
  output logic                        trace_interrupt_o,
  output logic [dword_width_p-1:0]    trace_data_o,

  output logic                        error_o,
  output logic [2:0]                  error_code_o
);

  // Queue index width, pointer width (extra wrap bit), wait counter width.
  localparam int unsigned AW = $clog2(els_p);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned WW = $clog2(timeout_p + 1);

  localparam logic [2:0] ERR_NONE   = 3'd0;
  localparam logic [2:0] ERR_CQ_OVF = 3'd1;
  localparam logic [2:0] ERR_WQ_OVF = 3'd2;
  localparam logic [2:0] ERR_ADDR   = 3'd3;
  localparam logic [2:0] ERR_TMO    = 3'd4;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_ERROR = 1'b1
  } state_e;

  state_e r_state;
  state_e w_state_nxt;

  logic [2:0]  r_error_code;
  logic [2:0]  w_error_code_nxt;
  logic [WW-1:0] r_wait;

  // Commit queue storage
  logic [vaddr_width_p-1:0]    r_cq_pc    [els_p];
  logic [instr_width_p-1:0]    r_cq_instr [els_p];
  logic                        r_cq_rd_w  [els_p];
  logic [reg_addr_width_p-1:0] r_cq_rd    [els_p];
  logic                        r_cq_intr  [els_p];
  logic [dword_width_p-1:0]    r_cq_cause [els_p];
  logic [PW-1:0]               r_cq_wr_ptr;
  logic [PW-1:0]               r_cq_rd_ptr;

  // Writeback queue storage
  logic [reg_addr_width_p-1:0] r_wq_addr  [els_p];
  logic [dword_width_p-1:0]    r_wq_data  [els_p];
  logic [PW-1:0]               r_wq_wr_ptr;
  logic [PW-1:0]               r_wq_rd_ptr;

  logic w_run;
  logic w_cq_empty, w_cq_full, w_wq_empty, w_wq_full;
  logic w_cq_req, w_cq_push, w_cq_pop, w_wq_push, w_wq_pop;
  logic w_head_rd_w, w_head_intr, w_head_ready, w_waiting;
  logic w_trace_v, w_fire;
  logic w_err_cq, w_err_wq, w_err_addr, w_err_tmo;
  logic [AW-1:0] w_cq_head, w_wq_head;
  logic [dword_width_p-1:0] w_head_data;

  assign w_run = (r_state == S_RUN);

  assign w_cq_head  = r_cq_rd_ptr[AW-1:0];
  assign w_wq_head  = r_wq_rd_ptr[AW-1:0];
  assign w_cq_empty = (r_cq_wr_ptr == r_cq_rd_ptr);
  assign w_wq_empty = (r_wq_wr_ptr == r_wq_rd_ptr);
  assign w_cq_full  = (r_cq_wr_ptr[AW] != r_cq_rd_ptr[AW]) &&
                      (r_cq_wr_ptr[AW-1:0] == r_cq_rd_ptr[AW-1:0]);
  assign w_wq_full  = (r_wq_wr_ptr[AW] != r_wq_rd_ptr[AW]) &&
                      (r_wq_wr_ptr[AW-1:0] == r_wq_rd_ptr[AW-1:0]);

  // Push only when not full at the start of the cycle; a same-cycle pop does not make room.
  assign w_cq_req  = commit_v_i | interrupt_v_i;
  assign w_cq_push = w_run & w_cq_req & ~w_cq_full;
  assign w_wq_push = w_run & wb_v_i & ~w_wq_full;

  assign w_head_rd_w  = r_cq_rd_w[w_cq_head];
  assign w_head_intr  = r_cq_intr[w_cq_head];
  assign w_head_ready = ~w_cq_empty & (~w_head_rd_w | ~w_wq_empty);
  assign w_waiting    = ~w_cq_empty & w_head_rd_w & w_wq_empty;

  assign w_trace_v = w_run & w_head_ready;
  assign w_fire    = w_trace_v & trace_ready_i;
  assign w_cq_pop  = w_fire;
  assign w_wq_pop  = w_fire & w_head_rd_w;

  // Error sources, evaluated only while running.
  assign w_err_cq   = w_run & w_cq_req & w_cq_full;
  assign w_err_wq   = w_run & wb_v_i & w_wq_full;
  assign w_err_addr = w_fire & w_head_rd_w & (r_cq_rd[w_cq_head] != r_wq_addr[w_wq_head]);
  assign w_err_tmo  = w_run & (r_wait == WW'(timeout_p));

  // Record payload: writeback data, trap cause, or zero.
  always_comb begin
    w_head_data = '0;
    if (w_head_rd_w) begin
      w_head_data = r_wq_data[w_wq_head];
    end else if (w_head_intr) begin
      w_head_data = r_cq_cause[w_cq_head];
    end
  end

  assign trace_v_o         = w_trace_v;
  assign trace_pc_o        = w_trace_v ? r_cq_pc[w_cq_head]    : '0;
  assign trace_instr_o     = w_trace_v ? r_cq_instr[w_cq_head] : '0;
  assign trace_interrupt_o = w_trace_v & w_head_intr;
  assign trace_data_o      = w_trace_v ? w_head_data : '0;
  assign error_o           = (r_state == S_ERROR);
  assign error_code_o      = r_error_code;

  // State register and sticky error code.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= S_RUN;
      r_error_code <= ERR_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_error_code <= w_error_code_nxt;
    end
  end

  // Next state: leave RUN on the first error, latching the lowest code seen that cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_error_code_nxt = r_error_code;
    if (r_state == S_RUN) begin
      if (w_err_cq) begin
        w_state_nxt      = S_ERROR;
        w_error_code_nxt = ERR_CQ_OVF;
      end else if (w_err_wq) begin
        w_state_nxt      = S_ERROR;
        w_error_code_nxt = ERR_WQ_OVF;
      end else if (w_err_addr) begin
        w_state_nxt      = S_ERROR;
        w_error_code_nxt = ERR_ADDR;
      end else if (w_err_tmo) begin
        w_state_nxt      = S_ERROR;
        w_error_code_nxt = ERR_TMO;
      end
    end
  end

  // Saturating wait counter for a head entry starved of its writeback.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wait <= '0;
    end else if (w_run) begin
      if (!w_waiting) begin
        r_wait <= '0;
      end else if (r_wait != WW'(timeout_p)) begin
        r_wait <= r_wait + WW'(1);
      end
    end
  end

  // Queue pointers; reset discards all queued entries.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cq_wr_ptr <= '0;
      r_cq_rd_ptr <= '0;
      r_wq_wr_ptr <= '0;
      r_wq_rd_ptr <= '0;
    end else begin
      if (w_cq_push) r_cq_wr_ptr <= r_cq_wr_ptr + PW'(1);
      if (w_cq_pop)  r_cq_rd_ptr <= r_cq_rd_ptr + PW'(1);
      if (w_wq_push) r_wq_wr_ptr <= r_wq_wr_ptr + PW'(1);
      if (w_wq_pop)  r_wq_rd_ptr <= r_wq_rd_ptr + PW'(1);
    end
  end

  // Queue storage writes; contents are only observed behind valid pointers.
  always_ff @(posedge clk_i) begin
    if (w_cq_push) begin
      r_cq_pc[r_cq_wr_ptr[AW-1:0]]    <= commit_pc_i;
      r_cq_instr[r_cq_wr_ptr[AW-1:0]] <= commit_instr_i;
      r_cq_rd_w[r_cq_wr_ptr[AW-1:0]]  <= commit_rd_w_v_i & ~interrupt_v_i;
      r_cq_rd[r_cq_wr_ptr[AW-1:0]]    <= commit_rd_addr_i;
      r_cq_intr[r_cq_wr_ptr[AW-1:0]]  <= interrupt_v_i;
      r_cq_cause[r_cq_wr_ptr[AW-1:0]] <= cause_i;
    end
    if (w_wq_push) begin
      r_wq_addr[r_wq_wr_ptr[AW-1:0]] <= wb_addr_i;
      r_wq_data[r_wq_wr_ptr[AW-1:0]] <= wb_data_i;
    end
  end

endmodule

// File: doc/bp_commit_trace_aligner.md
BP_COMMIT_TRACE_ALIGNER -- requirements
Module: bp_commit_trace_aligner

Interface
REQ-001 Parameters SHALL be: vaddr_width_p, default 39, PC width; instr_width_p, default 32, instruction width; dword_width_p, default 64, data and cause width; reg_addr_width_p, default 5, register address width.
REQ-002 Parameters SHALL continue: els_p, default 8, depth of each queue (power of 2, >=2); timeout_p, default 1024, maximum cycles a head entry may wait for its writeback.
REQ-003 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-004 Ports SHALL be:
- clk_i  in  1  clock
- reset_n_i  in  1  async active-low reset
- commit_v_i  in  1  instruction retired this cycle
- commit_pc_i  in  vaddr_width_p  retired PC
- commit_instr_i  in  instr_width_p  retired instruction
- commit_rd_w_v_i  in  1  retired instruction writes an integer register
- commit_rd_addr_i  in  reg_addr_width_p  destination register
- interrupt_v_i  in  1  trap taken this cycle
- cause_i  in  dword_width_p  trap cause
- wb_v_i  in  1  register writeback this cycle
- wb_addr_i  in  reg_addr_width_p  writeback register
- wb_data_i  in  dword_width_p  writeback data
- trace_v_o  out  1  aligned record valid
- trace_ready_i  in  1  consumer accepts record
- trace_pc_o  out  vaddr_width_p  record PC
- trace_instr_o  out  instr_width_p  record instruction
- trace_interrupt_o  out  1  record is a trap
- trace_data_o  out  dword_width_p  writeback data, cause for traps, 0 otherwise
- error_o  out  1  sticky error
- error_code_o  out  3  first error cause

Function
REQ-005 An event SHALL be enqueued into the commit queue when commit_v_i | interrupt_v_i; interrupt_v_i SHALL take precedence and force rd_w = 0.
REQ-006 Each wb_v_i SHALL be enqueued into the writeback queue; writebacks SHALL arrive in commit order, in the same cycle as or later than their commit.
REQ-007 A head commit entry SHALL be ready when rd_w = 0, or when rd_w = 1 and the writeback queue is non-empty.
REQ-008 trace_v_o SHALL equal (state == RUN) & head ready. The handshake SHALL occur on trace_v_o & trace_ready_i, which pops the commit head and, if rd_w = 1, the writeback head in the same cycle.
REQ-009 The queues SHALL have no bypass: an event enqueued in cycle N SHALL be visible at trace outputs no earlier than cycle N+1.
REQ-010 A push to a full queue SHALL be dropped even if a pop occurs in the same cycle.
REQ-011 trace_data_o SHALL be the writeback head data when rd_w = 1, cause when trace_interrupt_o = 1, and 0 otherwise. Outputs SHALL hold stable while trace_v_o & ~trace_ready_i.
REQ-012 The FSM SHALL have states RUN and ERROR. It SHALL move RUN->ERROR on the first error. ERROR SHALL be exited only by reset.
REQ-013 Error codes SHALL be: 0 none, 1 commit queue overflow, 2 writeback queue overflow, 3 address mismatch (handshake with rd_w = 1 and head rd_addr != writeback head addr), 4 timeout.
REQ-014 A wait counter SHALL increment each cycle the head has rd_w = 1 and the writeback queue is empty, and SHALL clear otherwise. Timeout SHALL fire when the count reaches timeout_p.
REQ-015 If several errors occur in one cycle, the lowest code SHALL be latched. error_code_o SHALL not change after the first error.
REQ-016 In ERROR, trace_v_o SHALL be 0 and both queues SHALL freeze; no pushes and no pops.
REQ-017 The wait counter SHALL be clog2(timeout_p+1) bits wide and SHALL saturate; it SHALL not wrap.
REQ-018 Queue pointers SHALL wrap modulo els_p. Full/empty SHALL be distinguished by an extra pointer bit or by an occupancy count.

Reset
REQ-019 While reset_n_i = 0, asynchronously: both queues empty, state RUN, wait counter 0, error_o = 0, error_code_o = 0, trace_v_o = 0.
REQ-020 Reset asserted mid-operation SHALL discard all queued entries. Inputs present in the cycle of reset deassertion SHALL be enqueued normally.

Verification
REQ-021 Commit pc=0x80000000, rd_w=0, trace_ready_i=1 -> trace_v_o=1 next cycle with pc 0x80000000 and data 0, then 0.
REQ-022 Commit rd_w=1 rd=5, then wb addr 5 data 0xDEAD 3 cycles later -> trace_v_o stays 0 until the cycle after the wb, then data 0xDEAD.
REQ-023 With trace_ready_i=0, 9 commits with els_p=8 -> error_o=1, code 1, trace_v_o=0 thereafter.
REQ-024 Commit rd=3, wb addr 4 -> code 3 at the handshake attempt. Separately, commit rd_w=1 with no wb for timeout_p cycles -> code 4.
REQ-025 interrupt_v_i and commit_v_i in the same cycle with cause 0x8000000000000007 -> one record, trace_interrupt_o=1, data 0x8000000000000007.
REQ-026 Reset pulse with 3 entries queued -> all outputs 0 asynchronously, no stale record after deassertion.
